// File: rtl/stdin_pkg.sv
// Shared types and constants for the stdin read controller slice.
package stdin_pkg;

  localparam int STDIN_DEPTH  = 1024;
  localparam int STDIN_ADDR_W = 10;
  localparam int WORD_BYTES   = 4;
  localparam int IDX_W        = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Final CPU-facing value: whole word, or low byte sign/zero-extended.
  function automatic logic [31:0] fmt_resp(input logic is_word, input logic sgn,
                                           input logic [31:0] w);
    if (is_word)  return w;
    else if (sgn) return {{24{w[7]}}, w[7:0]};
    else          return {24'h0, w[7:0]};
  endfunction

endpackage

// File: rtl/stdin_occupancy_tracker.sv
// Write-path register, buffer occupancy counter and sticky overflow flag.
module stdin_occupancy_tracker
  import stdin_pkg::*;
#(
  parameter int DEPTH  = STDIN_DEPTH,
  parameter int ADDR_W = STDIN_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              rd_en,
  output logic              mem_write_enable,
  output logic [7:0]        mem_write_data,
  output logic [ADDR_W:0]   occupancy,
  output logic              overflow
);

  localparam int OW = ADDR_W + 1;

  logic [OW-1:0] occ_q, occ_d;
  logic          we_q, we_d;
  logic [7:0]    wd_q;
  logic          ovf_q, ovf_d;
  logic          full;

  // Occupancy after this edge, counting the write and read the buffer sees now.
  always_comb begin
    occ_d = occ_q;
    if (we_q && !rd_en)      occ_d = occ_q + OW'(1);
    else if (!we_q && rd_en) occ_d = occ_q - OW'(1);
  end

  // Full is judged on the projected count so a committing write is not
  // double-booked into the last free slot.
  assign full  = (occ_d == OW'(DEPTH));
  assign we_d  = uart_rx_valid && !full;
  assign ovf_d = ovf_q || (uart_rx_valid && full);

  // Register write strobe/data and update count and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
      we_q  <= 1'b0;
      wd_q  <= 8'h00;
      ovf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      we_q  <= we_d;
      wd_q  <= uart_rx_data;
      ovf_q <= ovf_d;
    end
  end

  assign mem_write_enable = we_q;
  assign mem_write_data   = wd_q;
  assign occupancy        = occ_q;
  assign overflow         = ovf_q;

endmodule

// File: rtl/stdin_read_controller.sv
// Sequences UART bytes into the stdin buffer and serves CPU byte/word reads.
module stdin_read_controller
  import stdin_pkg::*;
#(
  parameter int DEPTH  = STDIN_DEPTH,
  parameter int ADDR_W = STDIN_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx_valid,
  input  logic [7:0]        uart_rx_data,
  input  logic              req_valid,
  input  logic              req_word,
  input  logic              req_signed,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              busy,
  output logic              mem_write_enable,
  output logic [7:0]        mem_write_data,
  output logic              mem_read_enable,
  input  logic [7:0]        mem_read_data,
  input  logic              mem_read_ready,
  output logic [ADDR_W:0]   occupancy,
  output logic              overflow,
  output logic              proto_err
);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             word_q, sgn_q;
  logic [31:0]      asm_q, asm_d;
  logic [31:0]      resp_q;
  logic             perr_q;

  stdin_occupancy_tracker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_occ (
    .clk              (clk),
    .reset            (reset),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_data     (uart_rx_data),
    .rd_en            (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .occupancy        (occupancy),
    .overflow         (overflow)
  );

  // One read pulse per ISSUE cycle, only when a byte is known to be buffered;
  // decoded from registered state and count, so it is glitch-free.
  assign mem_read_enable = (state_q == ISSUE) && (occupancy != '0);

  // Drop the returned byte into its little-endian lane.
  always_comb begin
    asm_d = asm_q;
    asm_d[{idx_q, 3'b000} +: 8] = mem_read_data;
  end

  // Read FSM: accept, issue/wait per byte, then present the result for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= 1'b0;
      sgn_q   <= 1'b0;
      asm_q   <= '0;
      resp_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            word_q  <= req_word;
            sgn_q   <= req_signed;
            idx_q   <= '0;
            asm_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_read_enable) state_q <= WAIT;
        end
        WAIT: begin
          if (mem_read_ready) begin
            asm_q <= asm_d;
            if (!word_q || idx_q == IDX_W'(WORD_BYTES - 1)) begin
              resp_q  <= fmt_resp(word_q, sgn_q, asm_d);
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ISSUE;
            end
          end else begin
            // Missing strobe: flag it and re-pulse; the count is not restored.
            perr_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q == ISSUE) || (state_q == WAIT);
  assign resp_valid = (state_q == DONE);
  assign resp_data  = resp_q;
  assign proto_err  = perr_q;

endmodule

// File: tb/tb_stdin_read_controller.sv
// Bench for stdin_read_controller with a small behavioural stdin buffer.
module tb_stdin_read_controller;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              uart_rx_valid;
  logic [7:0]        uart_rx_data;
  logic              req_valid, req_word, req_signed;
  logic              req_ready, resp_valid, busy;
  logic [31:0]       resp_data;
  logic              mem_write_enable, mem_read_enable, mem_read_ready;
  logic [7:0]        mem_write_data, mem_read_data;
  logic [ADDR_W:0]   occupancy;
  logic              overflow, proto_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  stdin_read_controller #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .uart_rx_valid    (uart_rx_valid),
    .uart_rx_data     (uart_rx_data),
    .req_valid        (req_valid),
    .req_word         (req_word),
    .req_signed       (req_signed),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .busy             (busy),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data),
    .mem_read_ready   (mem_read_ready),
    .occupancy        (occupancy),
    .overflow         (overflow),
    .proto_err        (proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural buffer: FIFO with ready one cycle after an accepted read.
  logic [7:0] bmem [0:7];
  logic [2:0] bwp, brp;
  logic [7:0] brd;
  logic       brdy;
  bit         withhold = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bwp <= '0; brp <= '0; brd <= 8'h00; brdy <= 1'b0;
    end else begin
      brdy <= 1'b0;
      if (mem_write_enable) begin
        bmem[bwp] <= mem_write_data;
        bwp <= bwp + 3'd1;
      end
      if (mem_read_enable && !withhold) begin
        brd  <= bmem[brp];
        brp  <= brp + 3'd1;
        brdy <= 1'b1;
      end
    end
  end
  assign mem_read_data  = brd;
  assign mem_read_ready = brdy;

  // Strobe counters and read-pulse timestamps.
  int rd_pulses = 0, wr_strobes = 0;
  int rd_log [0:63];
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_read_enable) begin
        rd_log[rd_pulses % 64] <= cyc;
        rd_pulses <= rd_pulses + 1;
      end
      if (mem_write_enable) wr_strobes <= wr_strobes + 1;
    end
  end

  // Scoreboard of expected responses; cyc < 0 means latency is not checked.
  typedef struct { logic [31:0] data; int cyc; } exp_t;
  exp_t sb [$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got %h, none expected", resp_data);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (resp_data !== mon_e.data) begin
          errors++;
          $display("FAIL resp_data: got %h expected %h", resp_data, mon_e.data);
        end
        if (mon_e.cyc >= 0) begin
          checks++;
          if (cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL resp_latency: got cycle %0d expected cycle %0d", cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rx_send(input logic [7:0] b);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    tick();
    uart_rx_valid = 1'b0;
  endtask

  // Hold req_valid until resp_valid (bounded), then release it.
  task automatic wait_resp();
    int n = 0;
    while (!resp_valid && n < 100) begin tick(); n++; end
    checks++;
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one within 100 cycles");
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic do_req(input bit w, input bit s, input logic [31:0] exp, input int lat);
    check("req_ready", req_ready, 1);
    sb.push_back('{exp, cyc + lat});
    req_valid = 1'b1; req_word = w; req_signed = s;
    wait_resp();
  endtask

  typedef struct {
    logic [31:0] payload;
    int          n;
    bit          word;
    bit          sgn;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [7];

  initial begin
    int p0, w0, n;
    vecs[0] = '{32'h12345678, 4, 1'b1, 1'b0, 32'h12345678};
    vecs[1] = '{32'h000000F0, 1, 1'b0, 1'b1, 32'hFFFFFFF0};
    vecs[2] = '{32'h000000F0, 1, 1'b0, 1'b0, 32'h000000F0};
    vecs[3] = '{32'h0000007F, 1, 1'b0, 1'b1, 32'h0000007F};
    vecs[4] = '{32'h00000080, 1, 1'b0, 1'b1, 32'hFFFFFF80};
    vecs[5] = '{32'hDEADBEEF, 4, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[6] = '{32'h00000000, 1, 1'b0, 1'b1, 32'h00000000};

    reset = 1'b1; uart_rx_valid = 1'b0; uart_rx_data = 8'h00;
    req_valid = 1'b0; req_word = 1'b0; req_signed = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_flags", {busy, resp_valid, mem_write_enable, mem_read_enable, overflow, proto_err}, 0);
    check("rst_occ", occupancy, 0);
    check("rst_resp_data", resp_data, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Table-driven byte/word reads with data already buffered.
    for (int v = 0; v < 7; v++) begin
      p0 = rd_pulses;
      for (int i = 0; i < vecs[v].n; i++) rx_send(vecs[v].payload[8*i +: 8]);
      tick(); tick();
      check("occ_filled", occupancy, vecs[v].n);
      do_req(vecs[v].word, vecs[v].sgn, vecs[v].exp, vecs[v].word ? 9 : 3);
      check("occ_drained", occupancy, 0);
      check("read_pulses", rd_pulses - p0, vecs[v].n);
      if (vecs[v].word)
        for (int i = 1; i < 4; i++)
          check("pulse_spacing", rd_log[(p0 + i) % 64] - rd_log[(p0 + i - 1) % 64], 2);
    end

    // Empty-buffer stall: byte arrives 5 cycles after the request.
    p0 = rd_pulses;
    sb.push_back('{32'h00000041, -1});
    req_valid = 1'b1; req_word = 1'b0; req_signed = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_busy_no_pulse", {busy, mem_read_enable}, 2'b10);
      tick();
    end
    rx_send(8'h41);
    n = 0;
    while (!resp_valid && n < 20) begin
      check("stall_busy", busy, 1);
      tick(); n++;
    end
    wait_resp();
    check("stall_one_pulse", rd_pulses - p0, 1);
    check("stall_occ", occupancy, 0);

    // Write commit and read pulse on the same edge at occupancy 1.
    rx_send(8'hA1);
    tick(); tick();
    sb.push_back('{32'h000000A1, cyc + 3});
    req_valid = 1'b1; req_word = 1'b0; req_signed = 1'b0;
    uart_rx_valid = 1'b1; uart_rx_data = 8'hB2;
    tick();
    uart_rx_valid = 1'b0;
    check("coincident_strobes", {mem_read_enable, mem_write_enable}, 2'b11);
    tick();
    check("coincident_occ", occupancy, 1);
    wait_resp();
    do_req(1'b0, 1'b0, 32'h000000B2, 3);

    // Overflow: six strobes into a 4-deep buffer.
    w0 = wr_strobes;
    rx_send(8'h11); rx_send(8'h22); rx_send(8'h33); rx_send(8'h44);
    check("ovf_before_5th", overflow, 0);
    rx_send(8'h55);
    check("ovf_after_5th", overflow, 1);
    rx_send(8'h66);
    tick(); tick();
    check("ovf_occ", occupancy, 4);
    check("ovf_write_strobes", wr_strobes - w0, 4);
    do_req(1'b1, 1'b0, 32'h44332211, 9);

    // Reset while waiting on the first byte of a word request.
    rx_send(8'h01); rx_send(8'h02); rx_send(8'h03); rx_send(8'h04);
    tick(); tick();
    req_valid = 1'b1; req_word = 1'b1; req_signed = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_flags", {busy, resp_valid, mem_write_enable, mem_read_enable, overflow, proto_err}, 0);
    check("midrst_occ", occupancy, 0);
    req_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    rx_send(8'h5A);
    tick(); tick();
    do_req(1'b0, 1'b1, 32'h0000005A, 3);

    // Buffer withholds the first ready strobe.
    withhold = 1'b1;
    rx_send(8'h33); rx_send(8'h44);
    tick(); tick();
    p0 = rd_pulses;
    sb.push_back('{32'h00000033, cyc + 5});
    req_valid = 1'b1; req_word = 1'b0; req_signed = 1'b0;
    tick();
    check("perr_first_pulse", mem_read_enable, 1);
    tick();
    check("perr_not_yet", proto_err, 0);
    tick();
    check("perr_set", proto_err, 1);
    check("perr_reissue", mem_read_enable, 1);
    withhold = 1'b0;
    wait_resp();
    check("perr_pulses", rd_pulses - p0, 2);
    check("perr_sticky", proto_err, 1);

    repeat (4) tick();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
